// File: rtl/systolic_pe_ws_if.sv
// Data, psum and weight-chain bundle for one weight-stationary systolic PE.
// The master side drives a PE. The slave side is the PE itself.
interface systolic_pe_ws_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_a;
  logic [ACC_W-1:0]  in_psum;
  logic              out_a_valid;
  logic [DATA_W-1:0] out_a;
  logic              out_valid;
  logic [ACC_W-1:0]  out_psum;
  logic              w_shift_en;
  logic [DATA_W-1:0] w_shift_in;
  logic [DATA_W-1:0] w_shift_out;
  logic              w_swap;
  logic              sat_flag;
  logic              clr_flag;

  modport master (
    output in_valid, in_a, in_psum, w_shift_en, w_shift_in, w_swap, clr_flag,
    input  out_a_valid, out_a, out_valid, out_psum, w_shift_out, sat_flag
  );

  modport slave (
    input  in_valid, in_a, in_psum, w_shift_en, w_shift_in, w_swap, clr_flag,
    output out_a_valid, out_a, out_valid, out_psum, w_shift_out, sat_flag
  );
endinterface

// File: rtl/systolic_pe_ws.sv
// Weight-stationary systolic PE with a double-buffered weight and a 2-stage MAC.
// The accumulate saturates or wraps. A daisy-chained shadow register reloads weights.
module systolic_pe_ws #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  systolic_pe_ws_if.slave pe
);
  localparam int PW     = 2 * DATA_W;
  localparam int STAGES = 2;

  if (DATA_W < 2 || ACC_W < PW) begin : g_bad_params
    $error("systolic_pe_ws: need DATA_W >= 2 and ACC_W >= 2*DATA_W");
  end

  logic [DATA_W-1:0] w_active, w_shadow;
  logic [DATA_W-1:0] a_r;
  logic [ACC_W-1:0]  psum_r, psum_o;
  logic [PW-1:0]     prod_c, prod_r;
  logic [STAGES-1:0] vld_pipe;
  logic [ACC_W:0]    prod_x, psum_x, sum;
  logic [ACC_W-1:0]  res;
  logic              ovf, flag;

  always_comb begin
    if (SIGNED)
      prod_c = $signed({{DATA_W{pe.in_a[DATA_W-1]}}, pe.in_a}) *
               $signed({{DATA_W{w_active[DATA_W-1]}}, w_active});
    else
      prod_c = PW'(pe.in_a) * PW'(w_active);
  end

  // One guard bit keeps the sum exact, so overflow is read off the top two bits.
  always_comb begin
    if (SIGNED) begin
      prod_x = {{(ACC_W + 1 - PW){prod_r[PW-1]}}, prod_r};
      psum_x = {psum_r[ACC_W-1], psum_r};
    end else begin
      prod_x = (ACC_W + 1)'(prod_r);
      psum_x = {1'b0, psum_r};
    end
    sum = psum_x + prod_x;
    ovf = SIGNED ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    res = sum[ACC_W-1:0];
    if (ovf && SATURATE) begin
      if (!SIGNED)          res = '1;
      else if (sum[ACC_W])  res = {1'b1, {(ACC_W-1){1'b0}}};
      else                  res = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      a_r      <= '0;
      psum_r   <= '0;
      prod_r   <= '0;
      psum_o   <= '0;
      flag     <= 1'b0;
      w_active <= '0;
      w_shadow <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], pe.in_valid};
      if (pe.in_valid) begin
        a_r    <= pe.in_a;
        psum_r <= pe.in_psum;
        prod_r <= prod_c;
      end
      if (vld_pipe[0]) psum_o <= res;
      if (vld_pipe[0] && ovf) flag <= 1'b1;
      else if (pe.clr_flag)   flag <= 1'b0;
      // Swap samples the pre-shift shadow; in-flight products keep the old weight.
      if (pe.w_swap)     w_active <= w_shadow;
      if (pe.w_shift_en) w_shadow <= pe.w_shift_in;
    end
  end

  assign pe.out_a       = a_r;
  assign pe.out_a_valid = vld_pipe[0];
  assign pe.out_valid   = vld_pipe[STAGES-1];
  assign pe.out_psum    = psum_o;
  assign pe.w_shift_out = w_shadow;
  assign pe.sat_flag    = flag;
endmodule
